hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Pipeline hazard controller for the 5-stage predicated core. Shadows the destination tag of every instruction issued from ID through EX, MEM and WB. From that shadow it drives the ID-stage `stall`, `ForwardA` and `ForwardB` controls. It also sequences multi-cycle stalls for operands that have no forwarding path: the predicate register Rp and the JR target register.

## Interface
Parameters:
- `NREG`, 32: architectural register count; tag width is clog2(NREG).
- `CNT_W`, 32: width of the performance counters (only with `HAZARD_PERF_EN`).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode_id`  in  5  opcode of the instruction in ID (IR[31:27]).
- `rs_id`  in  5  Rs field (IR[16:12]).
- `rt_id`  in  5  effective B-source tag (Rd for SW, else Rt).
- `rp_id`  in  5  predicate register field (IR[26:22]).
- `dest_id`  in  5  destination tag of the ID instruction (0 for SW, 31 for CALL).
- `regwr_id`  in  1  predicate-gated register-write enable of the ID instruction.
- `memrd_id`  in  1  predicate-gated load flag of the ID instruction.
- `stall`  out  1  holds PC and IF/ID and inserts a bubble into ID/EX.
- `ForwardA`  out  2  A-operand select: 0 = BusA, 1 = EX result, 2 = MEM result, 3 = WB result.
- `ForwardB`  out  2  B-operand select, same encoding as `ForwardA`.
- `stall_reason`  out  2  0 = none, 1 = load-use, 2 = predicate, 3 = JR target.
- `stall_cycles`  out  CNT_W  total stall cycles (only with `HAZARD_PERF_EN`).
- `fwd_events`  out  CNT_W  total cycles with a nonzero forward select (only with `HAZARD_PERF_EN`).

## Operation
- **Scoreboard.** Three slots: EX, MEM and WB. Each slot holds `{valid, dest, regwr, memrd}`.
- **Slot updates each cycle:**
  - WB ← MEM, MEM ← EX.
  - EX ← ID fields when `stall` = 0; EX ← bubble (valid = 0) when `stall` = 1.
- **Live slot.** A slot matches tag `r` only when all of these hold: valid, regwr, dest = r, r ≠ 0, r ≠ 30. The register file never writes R0 or R30, so those tags never forward and never stall.
- **Forward priority.** Nearest slot wins: EX (1), then MEM (2), then WB (3), then 0. `ForwardA` is evaluated on `rs_id` and `ForwardB` on `rt_id`.
- **Load-use hazard.** The EX slot matches `rs_id` or `rt_id` and has memrd = 1. Response: `stall` = 1, reason 1. Forward outputs are forced to 0 during a stall cycle, since the ID/EX register is cleared anyway.
- **Predicate hazard.** `rp_id` matches any live slot (EX, MEM or WB). The BusP path has no forwarding, so `stall` stays asserted until no slot matches; reason 2.
- **JR hazard.** `opcode_id` = JR and `rs_id` matches any live slot. JRTarget uses raw BusA, so the block stalls until clear; reason 3.
- **Reason priority:** predicate > JR > load-use.
- **State machine:** RUN and HOLD.
  - RUN → HOLD when any hazard is asserted.
  - HOLD → RUN on the first cycle with no hazard.
  - `stall` is a combinational function of the current slots and ID fields. The state exists for `stall_reason` continuity and the counters; it adds no latency.
- **Stall bound.** Load-use stalls for exactly 1 cycle. Predicate and JR stalls last at most 3 cycles, because each bubble advances the blocking producer one slot.

## Timing
- Reset (`reset` = 0, asynchronous): all slot valid bits = 0, state RUN, `stall` = 0, `ForwardA` = `ForwardB` = 0, `stall_reason` = 0, counters = 0.
- Reset deasserted mid-operation: slots come up empty, so no stale forwarding from pre-reset instructions.
- All outputs are combinational from the registered slots and ID inputs, valid in the same cycle.
- Slot state has 1-cycle latency from ID to the EX slot.
- Simultaneous hazard and forward in one cycle: the stall takes precedence and forward selects are 0.
- WB slot forwarding covers the same-cycle register write (write at the clock edge, asynchronous read before it).

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cycles` increments each cycle with `stall` = 1.
  - `fwd_events` increments each cycle with `ForwardA` ≠ 0 or `ForwardB` ≠ 0.
  - Both saturate at all-ones and clear on reset.
- `HAZARD_PERF_EN` undefined: both ports and counters are absent.

## Structure
- Shared package `core_pkg` holds:
  - opcode constants: `OP_LW` = 9, `OP_SW` = 10, `OP_J` = 11, `OP_CALL` = 12, `OP_JR` = 13;
  - forward-select constants: `FWD_REG`, `FWD_EX`, `FWD_MEM`, `FWD_WB`;
  - stall-reason constants;
  - the slot struct typedef.
- One sub-module, `fwd_select`: priority tag comparator returning a 2-bit select plus an any-match flag. Instantiate it for Rs, Rt and Rp.

## Test plan
- ADD R4,R2,R3 then ADD R5,R4,R1 → in cycle 2 `ForwardA` = 1, `stall` = 0.
- LW R4 then ADD R5,R4,R1 → one cycle with `stall` = 1 and reason 1, then `ForwardA` = 2.
- ADDI R6 followed by an instruction predicated on Rp = R6 → `stall` high for 3 consecutive cycles with reason 2, then low.
- ADD R31 into JR R31 → stall for 3 cycles with reason 3. Dest R0 or R30 followed by a consumer of R0 or R30 → no stall and Forward = 0.
- Assert reset while a load is in the EX slot → all outputs 0 immediately. After release, a dependent instruction shows no stall and Forward = 0.
- With `HAZARD_PERF_EN` defined, the load-use sequence above → `stall_cycles` = 1 and `fwd_events` = 1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the predicated 5-stage core: opcodes, forward selects,
// stall reasons and the scoreboard slot record used by hazard_scoreboard.
package core_pkg;

  localparam int TAG_W = 5;

  localparam logic [4:0] OP_LW   = 5'd9;
  localparam logic [4:0] OP_SW   = 5'd10;
  localparam logic [4:0] OP_J    = 5'd11;
  localparam logic [4:0] OP_CALL = 5'd12;
  localparam logic [4:0] OP_JR   = 5'd13;

  // R0 and R30 are never written by the register file, so they never forward or stall.
  localparam logic [TAG_W-1:0] REG_ZERO = TAG_W'(0);
  localparam logic [TAG_W-1:0] REG_NOWR = TAG_W'(30);

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RSN_NONE = 2'd0,
    RSN_LOAD = 2'd1,
    RSN_PRED = 2'd2,
    RSN_JR   = 2'd3
  } stall_rsn_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] dest;
    logic             regwr;
    logic             memrd;
  } slot_t;

  function automatic logic slot_live(input slot_t s, input logic [TAG_W-1:0] r);
    return s.valid && s.regwr && (s.dest == r) && (r != REG_ZERO) && (r != REG_NOWR);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority tag comparator: nearest live producer (EX, then MEM, then WB) wins;
// hit_o flags that any slot holds a pending write to tag_i.
module fwd_select
  import core_pkg::*;
(
  input  logic [TAG_W-1:0] tag_i,
  input  slot_t            ex_i,
  input  slot_t            mem_i,
  input  slot_t            wb_i,
  output fwd_sel_e         sel_o,
  output logic             hit_o
);

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    sel_o = FWD_REG;
    if (slot_live(ex_i, tag_i)) begin
      sel_o = FWD_EX;
    end else if (slot_live(mem_i, tag_i)) begin
      sel_o = FWD_MEM;
    end else if (slot_live(wb_i, tag_i)) begin
      sel_o = FWD_WB;
    end
  end

  assign hit_o = (sel_o != FWD_REG);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: shadows EX/MEM/WB destination tags and drives stall,
// forward selects and stall reason. Optional counters under HAZARD_PERF_EN.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int NREG  = 32
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              opcode_id,
  input  logic [$clog2(NREG)-1:0] rs_id,
  input  logic [$clog2(NREG)-1:0] rt_id,
  input  logic [$clog2(NREG)-1:0] rp_id,
  input  logic [$clog2(NREG)-1:0] dest_id,
  input  logic                    regwr_id,
  input  logic                    memrd_id,
  output logic                    stall,
  output logic [1:0]              ForwardA,
  output logic [1:0]              ForwardB,
  output logic [1:0]              stall_reason
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]        fwd_events
`endif
);

  typedef enum logic {ST_RUN, ST_HOLD} state_e;

  slot_t      ex_q, mem_q, wb_q;
  slot_t      ex_d;
  state_e     state_q, state_d;
  fwd_sel_e   sel_a, sel_b, sel_p;
  logic       hit_a, hit_b, hit_p;
  logic       load_use, pred_haz, jr_haz, hazard;
  stall_rsn_e reason;

  fwd_select u_fwd_rs (.tag_i(rs_id), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(sel_a), .hit_o(hit_a));
  fwd_select u_fwd_rt (.tag_i(rt_id), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(sel_b), .hit_o(hit_b));
  fwd_select u_fwd_rp (.tag_i(rp_id), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(sel_p), .hit_o(hit_p));

  // A load result is only available from MEM onward, so an EX-slot match on a load must wait a cycle.
  assign load_use = ex_q.memrd && ((sel_a == FWD_EX) || (sel_b == FWD_EX));
  assign pred_haz = hit_p;
  assign jr_haz   = (opcode_id == OP_JR) && hit_a;
  assign hazard   = pred_haz || jr_haz || load_use;

  always_comb begin
    reason = RSN_NONE;
    if (pred_haz) begin
      reason = RSN_PRED;
    end else if (jr_haz) begin
      reason = RSN_JR;
    end else if (load_use) begin
      reason = RSN_LOAD;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (hazard)  state_d = ST_HOLD;
      ST_HOLD: if (!hazard) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign stall        = hazard;
  // ID/EX is cleared on a stall, so any forward select would be discarded anyway.
  assign ForwardA     = hazard ? FWD_REG : sel_a;
  assign ForwardB     = hazard ? FWD_REG : sel_b;
  assign stall_reason = ((state_q == ST_HOLD) || hazard) ? reason : RSN_NONE;

  always_comb begin
    ex_d = '0;
    if (!hazard) begin
      ex_d.valid = 1'b1;
      ex_d.dest  = dest_id;
      ex_d.regwr = regwr_id;
      ex_d.memrd = memrd_id;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= ST_RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (((ForwardA != 2'd0) || (ForwardB != 2'd0)) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign fwd_events   = fwd_cnt_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, predicate and JR stalls,
// R0/R30 exclusion, asynchronous reset and (with HAZARD_PERF_EN) the counters.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] opcode_id = '0, rs_id = '0, rt_id = '0, rp_id = '0, dest_id = '0;
  logic       regwr_id = 1'b0, memrd_id = 1'b0;
  logic       stall;
  logic [1:0] ForwardA, ForwardB, stall_reason;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, fwd_events;
`endif

  int checks = 0;
  int errors = 0;
  logic [6:0] obs;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id), .rp_id(rp_id),
    .dest_id(dest_id), .regwr_id(regwr_id), .memrd_id(memrd_id),
    .stall(stall), .ForwardA(ForwardA), .ForwardB(ForwardB), .stall_reason(stall_reason)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .fwd_events(fwd_events)
`endif
  );

  always #5 clk = ~clk;

  // Present a new ID instruction 1 time unit after a rising edge, then settle.
  task automatic issue(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rp, input logic [4:0] dest, input logic wr, input logic rd);
    @(posedge clk);
    #1;
    opcode_id = op; rs_id = rs; rt_id = rt; rp_id = rp;
    dest_id = dest; regwr_id = wr; memrd_id = rd;
    #1;
    obs = {stall, ForwardA, ForwardB, stall_reason};
  endtask

  task automatic nop();
    issue(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    repeat (3) nop();
  endtask

  task automatic test_reset();
    #2;
    obs = {stall, ForwardA, ForwardB, stall_reason};
    if (obs !== 7'b0) begin errors++; $display("FAIL reset_state: got %b want %b", obs, 7'b0); end
    checks++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ex_forward();
    flush();
    issue(5'd0, 5'd2, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0);  // ADD R4,R2,R3
    if (obs !== 7'b0) begin errors++; $display("FAIL ex_fwd_producer: got %b want %b", obs, 7'b0); end
    checks++;
    issue(5'd0, 5'd4, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);  // ADD R5,R4,R1
    if (obs !== {1'b0, 2'd1, 2'd0, 2'd0}) begin errors++; $display("FAIL ex_fwd_consumer: got %b want %b", obs, {1'b0, 2'd1, 2'd0, 2'd0}); end
    checks++;
  endtask

  task automatic test_priority_wb();
    flush();
    issue(5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);  // R9 producer
    nop();
    nop();
    issue(5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);  // B operand R9, producer in WB
    if (obs !== {1'b0, 2'd0, 2'd3, 2'd0}) begin errors++; $display("FAIL wb_fwd_b: got %b want %b", obs, {1'b0, 2'd0, 2'd3, 2'd0}); end
    checks++;
    flush();
    issue(5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    issue(5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);  // R9 again: EX and MEM both match
    issue(5'd0, 5'd9, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    if (obs !== {1'b0, 2'd1, 2'd1, 2'd0}) begin errors++; $display("FAIL nearest_wins: got %b want %b", obs, {1'b0, 2'd1, 2'd1, 2'd0}); end
    checks++;
  endtask

  task automatic test_load_use();
    flush();
    issue(5'd9, 5'd2, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);  // LW R4
    issue(5'd0, 5'd4, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);  // ADD R5,R4,R1
    if (obs !== {1'b1, 2'd0, 2'd0, 2'd1}) begin errors++; $display("FAIL load_use_stall: got %b want %b", obs, {1'b1, 2'd0, 2'd0, 2'd1}); end
    checks++;
    @(posedge clk); #2;                               // instruction held in ID
    obs = {stall, ForwardA, ForwardB, stall_reason};
    if (obs !== {1'b0, 2'd2, 2'd0, 2'd0}) begin errors++; $display("FAIL load_use_mem_fwd: got %b want %b", obs, {1'b0, 2'd2, 2'd0, 2'd0}); end
    checks++;
  endtask

  task automatic test_predicate();
    flush();
    issue(5'd0, 5'd1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);  // ADDI R6
    issue(5'd0, 5'd2, 5'd3, 5'd6, 5'd7, 1'b1, 1'b0);  // predicated on R6
    for (int i = 0; i < 3; i++) begin
      if (obs !== {1'b1, 2'd0, 2'd0, 2'd2}) begin errors++; $display("FAIL pred_stall_%0d: got %b want %b", i, obs, {1'b1, 2'd0, 2'd0, 2'd2}); end
      checks++;
      @(posedge clk); #2;
      obs = {stall, ForwardA, ForwardB, stall_reason};
    end
    if (obs !== 7'b0) begin errors++; $display("FAIL pred_release: got %b want %b", obs, 7'b0); end
    checks++;
    // Predicate outranks load-use when both fire.
    flush();
    issue(5'd9, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);  // LW R7
    issue(5'd0, 5'd7, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    if (obs !== {1'b1, 2'd0, 2'd0, 2'd2}) begin errors++; $display("FAIL pred_over_load: got %b want %b", obs, {1'b1, 2'd0, 2'd0, 2'd2}); end
    checks++;
  endtask

  task automatic test_jr();
    flush();
    issue(5'd0, 5'd1, 5'd2, 5'd0, 5'd31, 1'b1, 1'b0); // ADD R31
    issue(5'd13, 5'd31, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); // JR R31
    for (int i = 0; i < 3; i++) begin
      if (obs !== {1'b1, 2'd0, 2'd0, 2'd3}) begin errors++; $display("FAIL jr_stall_%0d: got %b want %b", i, obs, {1'b1, 2'd0, 2'd0, 2'd3}); end
      checks++;
      @(posedge clk); #2;
      obs = {stall, ForwardA, ForwardB, stall_reason};
    end
    if (obs !== 7'b0) begin errors++; $display("FAIL jr_release: got %b want %b", obs, 7'b0); end
    checks++;
  endtask

  task automatic test_r0_r30();
    flush();
    issue(5'd9, 5'd0, 5'd0, 5'd0, 5'd30, 1'b1, 1'b1);  // load into R30
    issue(5'd13, 5'd30, 5'd30, 5'd30, 5'd0, 1'b0, 1'b0);
    if (obs !== 7'b0) begin errors++; $display("FAIL r30_excluded: got %b want %b", obs, 7'b0); end
    checks++;
    issue(5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);   // load into R0
    issue(5'd13, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    if (obs !== 7'b0) begin errors++; $display("FAIL r0_excluded: got %b want %b", obs, 7'b0); end
    checks++;
  endtask

  task automatic test_reset_midop();
    flush();
    issue(5'd9, 5'd2, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);   // LW R4
    issue(5'd0, 5'd4, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
    if (obs !== {1'b1, 2'd0, 2'd0, 2'd1}) begin errors++; $display("FAIL midop_pre_stall: got %b want %b", obs, {1'b1, 2'd0, 2'd0, 2'd1}); end
    checks++;
    #1 reset = 1'b0;
    #1 obs = {stall, ForwardA, ForwardB, stall_reason};
    if (obs !== 7'b0) begin errors++; $display("FAIL midop_reset_now: got %b want %b", obs, 7'b0); end
    checks++;
    @(negedge clk);
    reset = 1'b1;
    issue(5'd0, 5'd4, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    if (obs !== 7'b0) begin errors++; $display("FAIL midop_no_stale: got %b want %b", obs, 7'b0); end
    checks++;
`ifdef HAZARD_PERF_EN
    if ({stall_cycles, fwd_events} !== 64'd0) begin errors++; $display("FAIL perf_cleared: got %0d/%0d want 0/0", stall_cycles, fwd_events); end
    checks++;
    issue(5'd9, 5'd2, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);   // LW R4
    issue(5'd0, 5'd4, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);   // stall, then MEM forward
    @(posedge clk); #2;
    flush();
    if (stall_cycles !== 32'd1) begin errors++; $display("FAIL perf_stall_cycles: got %0d want 1", stall_cycles); end
    checks++;
    if (fwd_events !== 32'd1) begin errors++; $display("FAIL perf_fwd_events: got %0d want 1", fwd_events); end
    checks++;
`endif
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_priority_wb();
    test_load_use();
    test_predicate();
    test_jr();
    test_r0_r30();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
